// File: rtl/mips_pkg.sv
// +--------------------------------------------------------------------+
// | mips_pkg : shared ALU control encodings for the MIPS execute stage |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADDS = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_ANDN = 3'b100;
  localparam logic [ALU_CTRL_W-1:0] ALU_ORN  = 3'b101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// +--------------------------------------------------------------------+
// | alu_core : WIDTH-bit ALU with zero and carry-out flags             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_core
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [ALU_CTRL_W-1:0] ctrl,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  cout
);

  logic             w_invert;
  logic [WIDTH-1:0] w_bb;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_wide;

  // ctrl[2] turns the adder into a subtractor: a + ~b + 1.
  assign w_invert = ctrl[2];
  assign w_bb     = w_invert ? ~b : b;
  assign w_wide   = {1'b0, a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, w_invert};
  assign w_sum    = w_wide[WIDTH-1:0];
  assign cout     = w_wide[WIDTH];

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = w_sum;
      ALU_ADDS: result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1]};
      ALU_ANDN: result = a & w_bb;
      ALU_ORN:  result = a | w_bb;
      ALU_SUB:  result = w_sum;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1]};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/alu_stage_unit.sv
// +--------------------------------------------------------------------+
// | alu_stage_unit : operand mux, ALU and stallable result register    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_stage_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b_reg,
  input  logic [WIDTH-1:0]      b_imm,
  input  logic                  alu_src,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  cout,
  output logic [WIDTH-1:0]      result_q
);

  logic [WIDTH-1:0] w_src_b;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_result_q;

  assign w_src_b = alu_src ? b_imm : b_reg;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a      (a),
    .b      (w_src_b),
    .ctrl   (alu_ctrl),
    .result (w_result),
    .zero   (zero),
    .cout   (cout)
  );

  // Reset wins over enable; en=0 is a stall and holds the value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result_q <= RESET_VALUE;
    end else if (en) begin
      r_result_q <= w_result;
    end
  end

  assign result   = w_result;
  assign result_q = r_result_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_stage_unit.sv
// +--------------------------------------------------------------------+
// | tb_alu_stage_unit : model-checked bench for alu_stage_unit         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_stage_unit;

  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'h0040_0000;

  logic          clk = 1'b0;
  logic          reset, en, alu_src;
  logic [W-1:0]  a, b_reg, b_imm;
  logic [2:0]    alu_ctrl;
  logic [W-1:0]  result, result_q;
  logic          zero, cout;

  int n_tests = 0;
  int n_fail  = 0;

  logic          run_chk = 1'b0;
  logic          q_valid = 1'b0;
  logic [W-1:0]  model_q;
  logic [W:0]    tb_ref;

  always #5 clk = ~clk;

  alu_stage_unit #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .a        (a),
    .b_reg    (b_reg),
    .b_imm    (b_imm),
    .alu_src  (alu_src),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero),
    .cout     (cout),
    .result_q (result_q)
  );

  // Returns {cout, result}. Subtract-family carry is "no borrow", i.e. x >= y unsigned.
  function automatic logic [32:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] op);
    logic [32:0] add;
    logic [31:0] diff;
    logic        c_sub;
    add   = {1'b0, x} + {1'b0, y};
    diff  = x - y;
    c_sub = (x >= y);
    case (op)
      3'b000:  return {add[32], x & y};
      3'b001:  return {add[32], x | y};
      3'b010:  return add;
      3'b011:  return {add[32], 31'b0, add[31]};
      3'b100:  return {c_sub, x & ~y};
      3'b101:  return {c_sub, x | ~y};
      3'b110:  return {c_sub, diff};
      default: return {c_sub, 31'b0, diff[31]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always_comb tb_ref = ref_alu(a, alu_src ? b_imm : b_reg, alu_ctrl);

  always @(posedge clk) begin
    if (reset) begin
      model_q <= RV;
      q_valid <= 1'b1;
    end else if (en) begin
      model_q <= tb_ref[W-1:0];
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("model_result", {32'b0, result}, {32'b0, tb_ref[W-1:0]});
      chk("model_zero", {63'b0, zero}, {63'b0, (tb_ref[W-1:0] == '0)});
      chk("model_cout", {63'b0, cout}, {63'b0, tb_ref[W]});
      if (q_valid) chk("model_result_q", {32'b0, result_q}, {32'b0, model_q});
    end
  end

  task automatic dir(input string name, input logic [31:0] ia, input logic [31:0] ibr,
                     input logic [31:0] ibi, input logic isrc, input logic [2:0] ictrl,
                     input logic [31:0] er, input logic ez, input logic ec);
    a = ia; b_reg = ibr; b_imm = ibi; alu_src = isrc; alu_ctrl = ictrl;
    #1;
    chk({name, "_result"}, {32'b0, result}, {32'b0, er});
    chk({name, "_zero"}, {63'b0, zero}, {63'b0, ez});
    chk({name, "_cout"}, {63'b0, cout}, {63'b0, ec});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; alu_src = 1'b0; alu_ctrl = 3'b000;
    a = '0; b_reg = '0; b_imm = '0;
    run_chk = 1'b1;

    chk("pin_add", {31'b0, ref_alu(32'd5, 32'hFFFF_FFFF, 3'b010)}, {31'b0, 33'h1_0000_0004});
    chk("pin_sub", {31'b0, ref_alu(32'd7, 32'd8, 3'b110)}, {31'b0, 33'h0_FFFF_FFFF});

    @(posedge clk); #1;
    chk("reset_q", {32'b0, result_q}, {32'b0, RV});
    reset = 1'b0;

    @(posedge clk); #1;
    dir("add_imm", 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 3'b010, 32'd4, 1'b0, 1'b1);
    dir("sub_eq", 32'd7, 32'd7, 32'd0, 1'b0, 3'b110, 32'd0, 1'b1, 1'b1);
    dir("sub_neg", 32'd7, 32'd8, 32'd0, 1'b0, 3'b110, 32'hFFFF_FFFF, 1'b0, 1'b0);
    dir("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 3'b000, 32'hF000_F000, 1'b0, 1'b1);
    dir("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b1);
    dir("andn", 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 3'b100, 32'h00F0_00F0, 1'b0, 1'b0);
    dir("slt_lt", 32'd5, 32'd7, 32'd0, 1'b0, 3'b111, 32'd1, 1'b0, 1'b0);
    dir("slt_gt", 32'd7, 32'd5, 32'd0, 1'b0, 3'b111, 32'd0, 1'b1, 1'b1);
    dir("slt_neg", 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b111, 32'd1, 1'b0, 1'b1);
    dir("slt_eq", 32'd3, 32'd3, 32'd0, 1'b0, 3'b111, 32'd0, 1'b1, 1'b1);

    // PC-style use: reset, one increment, then a three-cycle stall.
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("pc_reset", {32'b0, result_q}, {32'b0, RV});
    a = RV; b_imm = 32'd4; alu_src = 1'b1; alu_ctrl = 3'b010; en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    chk("pc_incr", {32'b0, result_q}, {32'b0, 32'h0040_0004});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("pc_stall", {32'b0, result_q}, {32'b0, 32'h0040_0004});
    end

    // Reset beats enable; combinational result stays live under reset.
    a = 32'h1234; b_reg = '0; alu_src = 1'b0; alu_ctrl = 3'b001; en = 1'b1; reset = 1'b1;
    #1; chk("rst_comb_live", {32'b0, result}, {32'b0, 32'h1234});
    @(posedge clk); #1; reset = 1'b0;
    chk("rst_over_en", {32'b0, result_q}, {32'b0, RV});
    @(posedge clk); #1; en = 1'b0;
    chk("load_1234", {32'b0, result_q}, {32'b0, 32'h1234});

    // Reset raised between edges must not touch result_q before the next edge.
    @(negedge clk); #1; reset = 1'b1;
    #1; chk("rst_sync_hold", {32'b0, result_q}, {32'b0, 32'h1234});
    @(posedge clk); #1; reset = 1'b0;
    chk("rst_sync_take", {32'b0, result_q}, {32'b0, RV});

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      reset    = ($urandom_range(15) == 0);
      en       = $urandom_range(1);
      alu_src  = $urandom_range(1);
      alu_ctrl = 3'($urandom_range(7));
      a        = ($urandom_range(3) == 0) ? 32'($urandom_range(8)) : $urandom;
      b_reg    = ($urandom_range(3) == 0) ? a : $urandom;
      b_imm    = ($urandom_range(1) == 0) ? {{16{1'b1}}, 16'($urandom)} : 32'($urandom_range(100));
    end

    @(negedge clk); #1;
    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
